lcd_ddram_mirror: RTL and testbench



---
 rtl/lcd_ddram_mirror.sv | 221 ++++++++++++++++++++++
 tb/tb_lcd_ddram_mirror.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_ddram_mirror.sv
// lcd_ddram_mirror: passive sniffer of an HD44780-style 8-bit, 2-line LCD bus.
// It decodes writes into a 32-byte shadow of the visible DDRAM
// (line 1 at 0x00-0x0F, line 2 at 0x40-0x4F) and exposes a registered read port.
// Optional macro LCD_MIRROR_CKSUM_EN: maintain ddram_sum, the mod-256 sum of all
// shadow bytes; when undefined, ddram_sum is tied to zero.
module lcd_ddram_mirror #(
    parameter int SYNC_STAGES = 2,
    parameter int COLS        = 16
) (
    input  logic       CLOCK_50,
    input  logic       rst,
    input  logic       lcd_en,
    input  logic       lcd_rs,
    input  logic       lcd_rw,
    input  logic [7:0] lcd_data,
    input  logic [4:0] rd_addr,
    output logic [7:0] rd_char,
    output logic [6:0] addr_cnt,
    output logic       entry_inc,
    output logic       disp_on,
    output logic       busy,
    output logic       cmd_pulse,
    output logic       frame_done,
    output logic       drop_pulse,
    output logic [7:0] ddram_sum
);

    localparam int DEPTH = 2 * COLS;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_FILL = 1'b1;

    logic [SYNC_STAGES-1:0] en_sh;
    logic [SYNC_STAGES-1:0] rs_sh;
    logic [SYNC_STAGES-1:0] rw_sh;
    logic [7:0]             data_sh [SYNC_STAGES];
    logic                   en_d;

    logic       en_sync;
    logic       rs_sync;
    logic       rw_sync;
    logic [7:0] data_sync;
    logic       wr_req;

    logic [0:0] state;
    logic [4:0] fill_idx;
    logic       cg_mode;
    logic [7:0] mem [DEPTH];

    logic       data_hit;
    logic [6:0] addr_next;
    logic       wr_en;
    logic [4:0] wr_idx;
    logic [7:0] wr_val;

    assign en_sync   = en_sh[SYNC_STAGES-1];
    assign rs_sync   = rs_sh[SYNC_STAGES-1];
    assign rw_sync   = rw_sh[SYNC_STAGES-1];
    assign data_sync = data_sh[SYNC_STAGES-1];

    // Falling edge of the synchronised enable with rw=0 is a bus write.
    assign wr_req   = en_d & ~en_sync & ~rw_sync;
    assign data_hit = (addr_cnt[5:4] == 2'b00);
    assign busy     = (state == ST_FILL);

    // Synchronise every LCD input and keep a delayed copy of enable.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            en_sh <= '0;
            rs_sh <= '0;
            rw_sh <= '0;
            en_d  <= 1'b0;
            for (int unsigned i = 0; i < SYNC_STAGES; i++) begin
                data_sh[i] <= '0;
            end
        end else begin
            en_sh      <= {en_sh[SYNC_STAGES-2:0], lcd_en};
            rs_sh      <= {rs_sh[SYNC_STAGES-2:0], lcd_rs};
            rw_sh      <= {rw_sh[SYNC_STAGES-2:0], lcd_rw};
            en_d       <= en_sync;
            data_sh[0] <= lcd_data;
            for (int unsigned i = 1; i < SYNC_STAGES; i++) begin
                data_sh[i] <= data_sh[i-1];
            end
        end
    end

    // Address counter step over the two 40-byte line ranges, wrapping between them.
    always_comb begin
        addr_next = addr_cnt;
        if (entry_inc) begin
            case (addr_cnt)
                7'h27:   addr_next = 7'h40;
                7'h67:   addr_next = 7'h00;
                default: addr_next = addr_cnt + 7'd1;
            endcase
        end else begin
            case (addr_cnt)
                7'h00:   addr_next = 7'h67;
                7'h40:   addr_next = 7'h27;
                default: addr_next = addr_cnt - 7'd1;
            endcase
        end
    end

    // Single shadow write port: fill has priority, otherwise a visible data write.
    always_comb begin
        wr_en  = 1'b0;
        wr_idx = '0;
        wr_val = '0;
        if (state == ST_FILL) begin
            wr_en  = 1'b1;
            wr_idx = fill_idx;
            wr_val = 8'h20;
        end else if (wr_req && rs_sync && !cg_mode && data_hit) begin
            wr_en  = 1'b1;
            wr_idx = {addr_cnt[6], addr_cnt[3:0]};
            wr_val = data_sync;
        end
    end

    // Shadow storage; contents are defined by the fill that follows every reset.
    always_ff @(posedge CLOCK_50) begin
        if (wr_en) begin
            mem[wr_idx] <= wr_val;
        end
    end

    // Registered read port.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            rd_char <= '0;
        end else begin
            rd_char <= mem[rd_addr];
        end
    end

    // Control: fill sequencing, instruction decode and mirrored LCD registers.
    always_ff @(posedge CLOCK_50) begin
        if (rst) begin
            state      <= ST_FILL;
            fill_idx   <= '0;
            addr_cnt   <= '0;
            entry_inc  <= 1'b1;
            disp_on    <= 1'b0;
            cg_mode    <= 1'b0;
            cmd_pulse  <= 1'b0;
            frame_done <= 1'b0;
            drop_pulse <= 1'b0;
        end else begin
            cmd_pulse  <= 1'b0;
            frame_done <= 1'b0;
            drop_pulse <= 1'b0;
            if (state == ST_FILL) begin
                fill_idx <= fill_idx + 5'd1;
                if (fill_idx == 5'd31) begin
                    state <= ST_IDLE;
                end
                if (wr_req) begin
                    drop_pulse <= 1'b1;
                end
            end else if (wr_req) begin
                if (rs_sync) begin
                    if (cg_mode) begin
                        drop_pulse <= 1'b1;
                    end else begin
                        addr_cnt <= addr_next;
                        if (addr_cnt == 7'h4F) begin
                            frame_done <= 1'b1;
                        end
                    end
                end else if (data_sync != 8'h00) begin
                    cmd_pulse <= 1'b1;
                    casez (data_sync)
                        8'b1???????: begin
                            if (data_sync[5:0] >= 6'h28) begin
                                drop_pulse <= 1'b1;
                            end else begin
                                addr_cnt <= data_sync[6:0];
                                cg_mode  <= 1'b0;
                            end
                        end
                        8'b01??????: cg_mode   <= 1'b1;
                        8'b00001???: disp_on   <= data_sync[2];
                        8'b000001??: entry_inc <= data_sync[1];
                        8'b0000001?: begin
                            addr_cnt <= '0;
                            cg_mode  <= 1'b0;
                        end
                        8'b00000001: begin
                            addr_cnt  <= '0;
                            entry_inc <= 1'b1;
                            cg_mode   <= 1'b0;
                            state     <= ST_FILL;
                            fill_idx  <= '0;
                        end
                        default: ; // function set / shift: no mirrored state
                    endcase
                end
            end
        end
    end

`ifdef LCD_MIRROR_CKSUM_EN
    logic [7:0] sum_q;

    // Incremental checksum; held at zero through a fill since 32*0x20 wraps to 0.
    always_ff @(posedge CLOCK_50) begin
        if (rst || state == ST_FILL) begin
            sum_q <= '0;
        end else if (wr_en) begin
            sum_q <= sum_q + wr_val - mem[wr_idx];
        end
    end

    assign ddram_sum = sum_q;
`else
    assign ddram_sum = '0;
`endif

endmodule

// File: tb/tb_lcd_ddram_mirror.sv
// Testbench for lcd_ddram_mirror: table vectors, hand sequences for fill/reset
// corners, and random bus traffic against a behavioural shadow model.
module tb_lcd_ddram_mirror;

    logic       clk = 1'b0;
    logic       rst;
    logic       lcd_en, lcd_rs, lcd_rw;
    logic [7:0] lcd_data;
    logic [4:0] rd_addr;
    logic [7:0] rd_char;
    logic [6:0] addr_cnt;
    logic       entry_inc, disp_on, busy, cmd_pulse, frame_done, drop_pulse;
    logic [7:0] ddram_sum;

    always #10 clk = ~clk;

    lcd_ddram_mirror #(.SYNC_STAGES(2), .COLS(16)) dut (
        .CLOCK_50  (clk),
        .rst       (rst),
        .lcd_en    (lcd_en),
        .lcd_rs    (lcd_rs),
        .lcd_rw    (lcd_rw),
        .lcd_data  (lcd_data),
        .rd_addr   (rd_addr),
        .rd_char   (rd_char),
        .addr_cnt  (addr_cnt),
        .entry_inc (entry_inc),
        .disp_on   (disp_on),
        .busy      (busy),
        .cmd_pulse (cmd_pulse),
        .frame_done(frame_done),
        .drop_pulse(drop_pulse),
        .ddram_sum (ddram_sum)
    );

    int errors = 0;
    int checks = 0;

    // cumulative pulse-cycle counters
    int n_cmd = 0, n_drop = 0, n_frame = 0;
    always @(posedge clk) begin
        if (cmd_pulse)  n_cmd++;
        if (drop_pulse) n_drop++;
        if (frame_done) n_frame++;
    end

    // behavioural model
    int m_mem [32];
    int m_addr, m_inc, m_disp, m_cg;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic int step_addr(input int a, input int inc);
        int p;
        p = (a >= 64) ? 40 + (a - 64) : a;
        p = inc ? (p + 1) % 80 : (p + 79) % 80;
        return (p < 40) ? p : 64 + (p - 40);
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 32; i++) m_mem[i] = 'h20;
        m_addr = 0; m_inc = 1; m_disp = 0; m_cg = 0;
    endtask

    function automatic int model_sum();
        int s = 0;
`ifdef LCD_MIRROR_CKSUM_EN
        for (int i = 0; i < 32; i++) s += m_mem[i];
`endif
        return s % 256;
    endfunction

    task automatic model_exec(input int rs, input int rw, input int d,
                              output int e_cmd, output int e_drop, output int e_frame);
        int a, idx;
        e_cmd = 0; e_drop = 0; e_frame = 0;
        if (rw != 0) return;
        if (rs != 0) begin
            if (m_cg != 0) begin
                e_drop = 1;
            end else begin
                if ((m_addr % 64) < 16) begin
                    idx = ((m_addr >= 64) ? 16 : 0) + (m_addr % 16);
                    m_mem[idx] = d;
                    if (idx == 31) e_frame = 1;
                end
                m_addr = step_addr(m_addr, m_inc);
            end
        end else if (d != 0) begin
            e_cmd = 1;
            if (d >= 'h80) begin
                a = d - 'h80;
                if ((a % 64) >= 'h28) e_drop = 1;
                else begin m_addr = a; m_cg = 0; end
            end else if (d >= 'h40) m_cg = 1;
            else if (d >= 'h20) ;
            else if (d >= 'h10) ;
            else if (d >= 'h08) m_disp = (d / 4) % 2;
            else if (d >= 'h04) m_inc = (d / 2) % 2;
            else if (d >= 'h02) begin m_addr = 0; m_cg = 0; end
            else begin
                m_addr = 0; m_inc = 1; m_cg = 0;
                for (int i = 0; i < 32; i++) m_mem[i] = 'h20;
            end
        end
    endtask

    task automatic strobe(input int rs, input int rw, input int d);
        @(negedge clk);
        lcd_rs = rs[0]; lcd_rw = rw[0]; lcd_data = d[7:0]; lcd_en = 1'b1;
        repeat (3) @(negedge clk);
        lcd_en = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) check({name, " busy timeout"}, int'(busy), 0);
    endtask

    task automatic bus_op(input int rs, input int rw, input int d,
                          output int dc, output int dd, output int df);
        int c0 = n_cmd, d0 = n_drop, f0 = n_frame;
        strobe(rs, rw, d);
        repeat (6) @(negedge clk);
        wait_idle("bus_op");
        repeat (2) @(negedge clk);
        dc = n_cmd - c0; dd = n_drop - d0; df = n_frame - f0;
    endtask

    task automatic read_idx(input int i, input int exp, input string name);
        @(negedge clk);
        rd_addr = i[4:0];
        @(negedge clk);
        check(name, int'(rd_char), exp);
    endtask

    task automatic check_all_shadow(input string name);
        for (int i = 0; i < 32; i++) read_idx(i, m_mem[i], name);
    endtask

    task automatic count_busy_edges(output int cnt);
        cnt = 0;
        while (busy && cnt < 100) begin
            @(posedge clk);
            #1;
            cnt++;
        end
    endtask

    task automatic wait_busy_rise(input string name);
        int n = 0;
        while (!busy && n < 20) begin
            @(posedge clk);
            #1;
            n++;
        end
        if (n >= 20) check({name, " busy rise timeout"}, int'(busy), 1);
    endtask

    typedef struct {
        int rs; int d;
        int e_addr; int e_inc; int e_disp;
        int e_cmd; int e_drop; int e_frame;
        int r_idx; int r_val;
    } vec_t;

    vec_t vt [28];

    initial begin
        int dc, dd, df, ec, ed, ef, cnt, d0, c0;
        int rs, rw, d;

        vt[0]  = '{0, 'h80, 'h00, 1, 0, 1, 0, 0, -1, 0};
        vt[1]  = '{1, 'h41, 'h01, 1, 0, 0, 0, 0,  0, 'h41};
        vt[2]  = '{1, 'h42, 'h02, 1, 0, 0, 0, 0,  1, 'h42};
        vt[3]  = '{0, 'hCF, 'h4F, 1, 0, 1, 0, 0, -1, 0};
        vt[4]  = '{1, 'h5A, 'h50, 1, 0, 0, 0, 1, 31, 'h5A};
        vt[5]  = '{0, 'h04, 'h50, 0, 0, 1, 0, 0, -1, 0};
        vt[6]  = '{0, 'hC0, 'h40, 0, 0, 1, 0, 0, -1, 0};
        vt[7]  = '{1, 'h31, 'h27, 0, 0, 0, 0, 0, 16, 'h31};
        vt[8]  = '{0, 'hA8, 'h27, 0, 0, 1, 1, 0, -1, 0};
        vt[9]  = '{0, 'h40, 'h27, 0, 0, 1, 0, 0, -1, 0};
        vt[10] = '{1, 'h55, 'h27, 0, 0, 0, 1, 0, 16, 'h31};
        vt[11] = '{0, 'h0C, 'h27, 0, 1, 1, 0, 0, -1, 0};
        vt[12] = '{0, 'h06, 'h27, 1, 1, 1, 0, 0, -1, 0};
        vt[13] = '{0, 'h02, 'h00, 1, 1, 1, 0, 0, -1, 0};
        vt[14] = '{0, 'h00, 'h00, 1, 1, 0, 0, 0, -1, 0};
        vt[15] = '{0, 'h30, 'h00, 1, 1, 1, 0, 0, -1, 0};
        vt[16] = '{0, 'h14, 'h00, 1, 1, 1, 0, 0, -1, 0};
        vt[17] = '{0, 'hE7, 'h67, 1, 1, 1, 0, 0, -1, 0};
        vt[18] = '{1, 'h77, 'h00, 1, 1, 0, 0, 0, -1, 0};
        vt[19] = '{0, 'h04, 'h00, 0, 1, 1, 0, 0, -1, 0};
        vt[20] = '{0, 'h80, 'h00, 0, 1, 1, 0, 0, -1, 0};
        vt[21] = '{1, 'h61, 'h67, 0, 1, 0, 0, 0,  0, 'h61};
        vt[22] = '{0, 'hC0, 'h40, 0, 1, 1, 0, 0, -1, 0};
        vt[23] = '{1, 'h62, 'h27, 0, 1, 0, 0, 0, 16, 'h62};
        vt[24] = '{0, 'h06, 'h27, 1, 1, 1, 0, 0, -1, 0};
        vt[25] = '{0, 'hA7, 'h27, 1, 1, 1, 0, 0, -1, 0};
        vt[26] = '{1, 'h63, 'h40, 1, 1, 0, 0, 0, -1, 0};
        vt[27] = '{0, 'h08, 'h40, 1, 0, 1, 0, 0, -1, 0};

        rst = 1'b1; lcd_en = 1'b0; lcd_rs = 1'b0; lcd_rw = 1'b0;
        lcd_data = '0; rd_addr = '0;
        model_reset();

        // reset state
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst rd_char", int'(rd_char), 0);
        check("rst addr_cnt", int'(addr_cnt), 0);
        check("rst entry_inc", int'(entry_inc), 1);
        check("rst disp_on", int'(disp_on), 0);
        check("rst busy", int'(busy), 1);
        check("rst pulses", int'({cmd_pulse, frame_done, drop_pulse}), 0);
        check("rst ddram_sum", int'(ddram_sum), 0);
        rst = 1'b0;
        count_busy_edges(cnt);
        check("init fill cycles", cnt, 32);
        check_all_shadow("init shadow");
        check("init addr_cnt", int'(addr_cnt), 0);
        check("init disp_on", int'(disp_on), 0);
        check("init ddram_sum", int'(ddram_sum), 0);

        // table vectors
        for (int i = 0; i < 28; i++) begin
            model_exec(vt[i].rs, 0, vt[i].d, ec, ed, ef);
            bus_op(vt[i].rs, 0, vt[i].d, dc, dd, df);
            check($sformatf("vec%0d addr_cnt", i), int'(addr_cnt), vt[i].e_addr);
            check($sformatf("vec%0d entry_inc", i), int'(entry_inc), vt[i].e_inc);
            check($sformatf("vec%0d disp_on", i), int'(disp_on), vt[i].e_disp);
            check($sformatf("vec%0d cmd_pulse", i), dc, vt[i].e_cmd);
            check($sformatf("vec%0d drop_pulse", i), dd, vt[i].e_drop);
            check($sformatf("vec%0d frame_done", i), df, vt[i].e_frame);
            check($sformatf("vec%0d ddram_sum", i), int'(ddram_sum), model_sum());
            if (vt[i].r_idx >= 0)
                read_idx(vt[i].r_idx, vt[i].r_val, $sformatf("vec%0d rd_char", i));
        end
        check_all_shadow("table shadow");

        // clear display with a data strobe landing mid-fill
        bus_op(0, 0, 'h04, dc, dd, df);
        model_exec(0, 0, 'h04, ec, ed, ef);
        check("pre-clear entry_inc", int'(entry_inc), 0);
        c0 = n_cmd; d0 = n_drop;
        strobe(0, 0, 'h01);
        model_exec(0, 0, 'h01, ec, ed, ef);
        wait_busy_rise("clear");
        fork
            count_busy_edges(cnt);
            begin
                repeat (5) @(negedge clk);
                lcd_rs = 1'b1; lcd_data = 8'h99; lcd_en = 1'b1;
                repeat (3) @(negedge clk);
                lcd_en = 1'b0;
            end
        join
        repeat (3) @(negedge clk);
        check("clear fill cycles", cnt, 32);
        check("clear cmd_pulse", n_cmd - c0, 1);
        check("clear drop_pulse", n_drop - d0, 1);
        check("clear entry_inc", int'(entry_inc), 1);
        check("clear addr_cnt", int'(addr_cnt), 0);
        check("clear ddram_sum", int'(ddram_sum), 0);
        check_all_shadow("clear shadow");

        // reset during a fill restarts it
        bus_op(0, 0, 'h0C, dc, dd, df);
        bus_op(1, 0, 'h4B, dc, dd, df);
        strobe(0, 0, 'h01);
        wait_busy_rise("refill");
        repeat (10) @(posedge clk);
        #1 rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("midfill rst busy", int'(busy), 1);
        check("midfill rst disp_on", int'(disp_on), 0);
        @(negedge clk);
        rst = 1'b0;
        model_reset();
        count_busy_edges(cnt);
        check("midfill restart cycles", cnt, 32);
        check_all_shadow("midfill shadow");

        // random traffic against the model
        for (int it = 0; it < 120; it++) begin
            rw = ($urandom_range(0, 3) == 0) ? 1 : 0;
            rs = $urandom_range(0, 1);
            d  = $urandom_range(0, 255);
            model_exec(rs, rw, d, ec, ed, ef);
            bus_op(rs, rw, d, dc, dd, df);
            check($sformatf("rnd%0d addr_cnt", it), int'(addr_cnt), m_addr);
            check($sformatf("rnd%0d entry_inc", it), int'(entry_inc), m_inc);
            check($sformatf("rnd%0d disp_on", it), int'(disp_on), m_disp);
            check($sformatf("rnd%0d cmd_pulse", it), dc, ec);
            check($sformatf("rnd%0d drop_pulse", it), dd, ed);
            check($sformatf("rnd%0d frame_done", it), df, ef);
            check($sformatf("rnd%0d ddram_sum", it), int'(ddram_sum), model_sum());
        end
        check_all_shadow("random shadow");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
